exec_ctrl: RTL and testbench
============================

EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 SHALL have parameter AW, default 2, meaning register-address width; it SHALL match the register file it drives.
REQ-002 SHALL have parameter PW, default 8, meaning program-counter width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  launches program execution from PC 0 when idle.
REQ-006 SHALL have port instr  input  9  instruction word at address pc, valid combinationally.
REQ-007 SHALL have port rd_nonzero  input  1  regfile ReadData1 != 0, sampled for BNZ.
REQ-008 SHALL have port pc  output  PW  instruction fetch address.
REQ-009 SHALL have ports ReadReg1, ReadReg2, WriteReg  output  AW  register-file addresses.
REQ-010 SHALL have ports WriteEnabled, WritePrepReg, ReadPrepReg  output  1 each  register-file controls.
REQ-011 SHALL have port alu_op  output  3  000 ADD, 001 SUB, 010 AND, 011 PASS_B, 100 PASS_A, 101 PASS_IMM.
REQ-012 SHALL have port imm  output  8  zero-extended instr[3:0] of the current instruction.
REQ-013 SHALL have ports busy, done  output  1 each  executing; one-cycle pulse on HALT.

Function
REQ-014 SHALL implement states IDLE, FETCH, DECODE, EXEC, WB, HALT; each instruction takes exactly 4 cycles: FETCH->DECODE->EXEC->WB.
REQ-015 IDLE: start=1 SHALL move to FETCH with pc=0; start is ignored in every other state.
REQ-016 FETCH SHALL latch instr into an internal instruction register ir; all decode uses ir, never live instr.
REQ-017 Field map SHALL be: op=ir[8:6], rd=ir[5:4], rs=ir[3:2], off=ir[3:0] as signed 4-bit.
REQ-018 ReadReg1=rd, ReadReg2=rs, WriteReg=rd, and alu_op/imm SHALL be held constant from DECODE through WB.
REQ-019 WriteEnabled SHALL be 1 only in WB, and only for ops 000-101; 0 in all other states and ops.
REQ-020 Ops 000 ADD, 001 SUB, 010 AND: rd <= rd op rs; alu_op=op.
REQ-021 Op 011 MOVP: prep <= regs[rs]; alu_op=PASS_B, WritePrepReg=1 during WB.
REQ-022 Op 100 LDP: rd <= prep; ReadPrepReg=1 DECODE through WB, alu_op=PASS_A.
REQ-023 Op 101 LI: rd <= imm; alu_op=PASS_IMM.
REQ-024 Op 110 BNZ: rd_nonzero SHALL be sampled in EXEC; if 1, pc <= pc + sign_ext(off) in WB, else pc <= pc+1.
REQ-025 Op 111 HALT: DECODE SHALL go to HALT, skipping EXEC/WB; done=1 for the single cycle in which the state becomes HALT.
REQ-026 All non-branch, non-halt ops SHALL set pc <= pc+1 in WB, then go to FETCH.
REQ-027 PC arithmetic SHALL be modulo 2^PW: 255+1=0; branch from 1 with off=-4 gives 253.
REQ-028 HALT SHALL hold pc and all outputs; it SHALL leave HALT only via reset.
REQ-029 busy SHALL be 1 in FETCH, DECODE, EXEC and WB, and 0 in IDLE and HALT.
REQ-030 WritePrepReg and ReadPrepReg SHALL be 0 outside DECODE-WB and for all ops other than MOVP/LDP respectively.

Reset
REQ-031 reset=1 SHALL set state=IDLE, pc=0, ir=0, and all outputs 0 (alu_op=000, imm=0), overriding start and any in-flight instruction.
REQ-032 Reset asserted during WB SHALL suppress that cycle's write: WriteEnabled is forced 0 in the reset cycle.

Verification
REQ-033 Bench SHALL cover: reset, start, LI r1,5 -> WriteEnabled=1, WriteReg=1, alu_op=101, imm=5 in cycle 4; pc=1 after.
REQ-034 Bench SHALL cover: MOVP rs=1 then LDP rd=2 -> WritePrepReg=1 in WB of the first; ReadPrepReg=1 in DECODE-WB of the second; WriteReg=2.
REQ-035 Bench SHALL cover: BNZ at pc=6, off=-3, rd_nonzero=1 -> pc=3; rd_nonzero=0 -> pc=7; WriteEnabled stays 0.
REQ-036 Bench SHALL cover: HALT at pc=9 -> done pulses exactly once, busy=0, pc stays 9; start is ignored until reset.
REQ-037 Bench SHALL cover: ADD at pc=255 -> pc wraps to 0.
REQ-038 Bench SHALL cover: reset asserted in WB of ADD -> no write, state=IDLE, pc=0 on the next cycle.

Source files
------------

// File: rtl/exec_ctrl.sv
// Multi-cycle execution controller: fetches 9-bit instructions, walks each through
// FETCH/DECODE/EXEC/WB and drives register-file, ALU and PC controls.
module exec_ctrl #(
    parameter int AW = 2,
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [8:0]    instr,
    input  logic          rd_nonzero,
    output logic [PW-1:0] pc,
    output logic [AW-1:0] ReadReg1,
    output logic [AW-1:0] ReadReg2,
    output logic [AW-1:0] WriteReg,
    output logic          WriteEnabled,
    output logic          WritePrepReg,
    output logic          ReadPrepReg,
    output logic [2:0]    alu_op,
    output logic [7:0]    imm,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
    } state_t;

    localparam logic [2:0] OP_MOVP = 3'b011;
    localparam logic [2:0] OP_LDP  = 3'b100;
    localparam logic [2:0] OP_LI   = 3'b101;
    localparam logic [2:0] OP_BNZ  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    state_t        state_q, state_d;
    logic [PW-1:0] pc_q, pc_d;
    logic [8:0]    ir_q, ir_d;
    logic          taken_q, taken_d;
    logic          done_q, done_d;

    logic [2:0]    op;
    logic [PW-1:0] off_ext;

    assign op      = ir_q[8:6];
    assign off_ext = PW'($signed(ir_q[3:0]));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            taken_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            taken_q <= taken_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        taken_d = taken_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            S_FETCH: begin
                ir_d    = instr;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (op == OP_HALT) begin
                    state_d = S_HALT;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                taken_d = rd_nonzero;
                state_d = S_WB;
            end
            S_WB: begin
                pc_d    = (op == OP_BNZ && taken_q) ? pc_q + off_ext : pc_q + 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Decoded fields stay visible from DECODE onward (and frozen in HALT);
    // everything is forced low while reset is asserted.
    logic in_dec, in_wb;
    assign in_dec = (state_q == S_DECODE) || (state_q == S_EXEC) ||
                    (state_q == S_WB)     || (state_q == S_HALT);
    assign in_wb  = (state_q == S_WB);

    always_comb begin
        ReadReg1     = '0;
        ReadReg2     = '0;
        WriteReg     = '0;
        WriteEnabled = 1'b0;
        WritePrepReg = 1'b0;
        ReadPrepReg  = 1'b0;
        alu_op       = 3'b000;
        imm          = '0;
        busy         = 1'b0;
        done         = 1'b0;
        if (!reset) begin
            busy = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                   (state_q == S_EXEC)  || (state_q == S_WB);
            done = done_q;
            if (in_dec) begin
                ReadReg1     = AW'(ir_q[5:4]);
                ReadReg2     = AW'(ir_q[3:2]);
                WriteReg     = AW'(ir_q[5:4]);
                imm          = {4'b0000, ir_q[3:0]};
                alu_op       = (op <= OP_LI) ? op : 3'b000;
                ReadPrepReg  = (op == OP_LDP) && (state_q != S_HALT);
                WriteEnabled = in_wb && (op <= OP_LI);
                WritePrepReg = in_wb && (op == OP_MOVP);
            end
        end
    end

    assign pc = pc_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// Randomized bench for exec_ctrl: an instruction-level model tracks the PC and
// expected per-phase controls while directed programs hit the corner cases.
module tb_exec_ctrl;
    logic       clk = 1'b0;
    logic       reset, start, rd_nonzero;
    logic [8:0] instr;
    logic [7:0] pc;
    logic [1:0] ReadReg1, ReadReg2, WriteReg;
    logic       WriteEnabled, WritePrepReg, ReadPrepReg;
    logic [2:0] alu_op;
    logic [7:0] imm;
    logic       busy, done;

    logic [8:0] mem [256];
    int total = 0, bad = 0;
    int pcm = 0;

    exec_ctrl #(.AW(2), .PW(8)) dut (
        .clk(clk), .reset(reset), .start(start), .instr(instr),
        .rd_nonzero(rd_nonzero), .pc(pc), .ReadReg1(ReadReg1),
        .ReadReg2(ReadReg2), .WriteReg(WriteReg), .WriteEnabled(WriteEnabled),
        .WritePrepReg(WritePrepReg), .ReadPrepReg(ReadPrepReg),
        .alu_op(alu_op), .imm(imm), .busy(busy), .done(done)
    );

    assign instr = mem[pc];
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] rand_alu();
        logic [8:0] w;
        w = 9'($urandom);
        w[8:6] = 3'($urandom_range(0, 5));
        return w;
    endfunction

    task automatic do_reset();
        start = 1'b0;
        reset = 1'b1;
        rd_nonzero = 1'b0;
        tick();
        chk("rst_we", WriteEnabled, 0);
        chk("rst_busy", busy, 0);
        tick();
        reset = 1'b0;
        chk("rst_pc", pc, 0);
        tick();
        chk("idle_busy", busy, 0);
        chk("idle_pc", pc, 0);
        chk("idle_alu", alu_op, 0);
        chk("idle_imm", imm, 0);
        chk("idle_done", done, 0);
        chk("idle_rr1", ReadReg1, 0);
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
        pcm = 0;
    endtask

    // Runs one instruction starting in its FETCH cycle; force_rn<0 means random branch input.
    task automatic run_instr(input int force_rn, input bit rst_wb);
        logic [8:0] w;
        logic signed [3:0] offs;
        int op, rd, rs, off;
        bit rn;
        w = mem[pcm];
        op = int'(w[8:6]); rd = int'(w[5:4]); rs = int'(w[3:2]);
        offs = w[3:0];
        off = offs;
        chk("f_busy", busy, 1);
        chk("f_pc", pc, pcm);
        chk("f_we", WriteEnabled, 0);
        start = 1'($urandom_range(0, 1));
        rd_nonzero = 1'($urandom_range(0, 1));
        tick();
        chk("d_rr1", ReadReg1, rd);
        chk("d_rr2", ReadReg2, rs);
        chk("d_we", WriteEnabled, 0);
        chk("d_rprep", ReadPrepReg, op == 4);
        if (op <= 5) begin
            chk("d_alu", alu_op, op);
            chk("d_imm", imm, w[3:0]);
        end
        tick();
        if (op == 7) begin
            chk("h_done", done, 1);
            chk("h_busy", busy, 0);
            chk("h_pc", pc, pcm);
            return;
        end
        rn = (force_rn < 0) ? 1'($urandom_range(0, 1)) : force_rn[0];
        rd_nonzero = rn;
        chk("e_we", WriteEnabled, 0);
        chk("e_wprep", WritePrepReg, 0);
        chk("e_rprep", ReadPrepReg, op == 4);
        tick();
        rd_nonzero = 1'($urandom_range(0, 1));
        chk("w_we", WriteEnabled, op <= 5);
        chk("w_wreg", WriteReg, rd);
        chk("w_wprep", WritePrepReg, op == 3);
        chk("w_rprep", ReadPrepReg, op == 4);
        if (op <= 5) chk("w_alu", alu_op, op);
        if (rst_wb) begin
            start = 1'b0;
            reset = 1'b1;
            #1;
            chk("rwb_we", WriteEnabled, 0);
            tick();
            reset = 1'b0;
            chk("rwb_busy", busy, 0);
            chk("rwb_pc", pc, 0);
            pcm = 0;
            return;
        end
        tick();
        pcm = (op == 6 && rn) ? ((pcm + off) & 255) : ((pcm + 1) & 255);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; rd_nonzero = 1'b0;

        // Program A: LI, MOVP/LDP, BNZ both ways, HALT at 9
        for (int i = 0; i < 256; i++) mem[i] = rand_alu();
        mem[0] = 9'b101_01_0101;
        mem[1] = 9'b011_00_01_00;
        mem[2] = 9'b100_10_0000;
        mem[6] = 9'b110_00_1101;
        mem[9] = 9'b111_000000;
        do_reset();
        go();
        for (int i = 0; i < 6; i++) run_instr(-1, 0);
        run_instr(1, 0);
        chk("bnz_taken_pc", pc, 3);
        for (int i = 0; i < 3; i++) run_instr(-1, 0);
        run_instr(0, 0);
        chk("bnz_fall_pc", pc, 7);
        for (int i = 0; i < 3; i++) run_instr(-1, 0);
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            tick();
            chk("hold_done", done, 0);
            chk("hold_busy", busy, 0);
            chk("hold_pc", pc, 9);
        end

        // Program B: PC wrap both directions, then random stream
        for (int i = 0; i < 256; i++) mem[i] = rand_alu();
        mem[0]   = 9'b110_01_1111;
        mem[1]   = 9'b110_00_1100;
        mem[255] = 9'b000_01_10_00;
        do_reset();
        go();
        run_instr(1, 0);
        chk("wrap_back_pc", pc, 255);
        run_instr(-1, 0);
        chk("wrap_fwd_pc", pc, 0);
        run_instr(0, 0);
        run_instr(1, 0);
        chk("bnz_m4_pc", pc, 253);
        for (int i = 0; i < 256; i++) begin
            mem[i] = 9'($urandom);
            mem[i][8:6] = 3'($urandom_range(0, 6));
        end
        for (int i = 0; i < 150; i++) run_instr(-1, 0);

        // Program C: reset in the WB of an ADD, then restart cleanly
        mem[0] = 9'b000_01_10_00;
        do_reset();
        go();
        run_instr(-1, 1);
        go();
        run_instr(-1, 0);
        chk("restart_pc", pc, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
